// File: rtl/mxregs_pkg.sv
// Shared definitions for the register bank read path.
// Holds the register index constants of the 16-entry bank, the address codes
// of the loader address map, the read sequencer state encoding, and a helper
// that maps the low address bits of a FLAGS pair code to its partner register.
package mxregs_pkg;

    localparam int BANK_DEPTH = 16;

    // Register indices within the bank
    localparam logic [3:0] REG_A     = 4'd0;
    localparam logic [3:0] REG_X     = 4'd1;
    localparam logic [3:0] REG_Y     = 4'd2;
    localparam logic [3:0] REG_D     = 4'd3;
    localparam logic [3:0] REG_INSP  = 4'd6;
    localparam logic [3:0] REG_FLAGS = 4'd7;
    localparam logic [3:0] REG_R2    = 4'd14;
    localparam logic [3:0] REG_R3    = 4'd15;

    // Paired address codes
    localparam logic [7:0] ADDR_FLAGS_A = 8'h10;
    localparam logic [7:0] ADDR_FLAGS_X = 8'h11;
    localparam logic [7:0] ADDR_FLAGS_Y = 8'h12;
    localparam logic [7:0] ADDR_FLAGS_D = 8'h13;
    localparam logic [7:0] ADDR_R2_INSP = 8'h80;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    // Second register of a FLAGS+A/X/Y/D pair, selected by addr[1:0]
    function automatic logic [3:0] flags_partner(input logic [1:0] sel);
        logic [3:0] idx;
        case (sel)
            2'd0:    idx = REG_A;
            2'd1:    idx = REG_X;
            2'd2:    idx = REG_Y;
            default: idx = REG_D;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/mxreg_read_sequencer_11_if.sv
// Request/response bus of the register read sequencer.
// Request side: req_addr, req_valid (from requester), req_ready (to requester).
// Response side: rsp_data, rsp_idx, rsp_last, rsp_err, rsp_valid (to consumer),
// rsp_ready (from consumer).
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; a source holds its valid payload stable until that edge, and
// ready may depend combinationally on the other side's valid.
// Modports: master = requester/consumer side, slave = sequencer side.
interface mxreg_read_sequencer_11_if #(
    parameter int WORD_LENGTH = 8
);
    logic [7:0]             req_addr;
    logic                   req_valid;
    logic                   req_ready;
    logic [WORD_LENGTH-1:0] rsp_data;
    logic [3:0]             rsp_idx;
    logic                   rsp_last;
    logic                   rsp_err;
    logic                   rsp_valid;
    logic                   rsp_ready;

    modport master (
        output req_addr, req_valid, rsp_ready,
        input  req_ready, rsp_data, rsp_idx, rsp_last, rsp_err, rsp_valid
    );

    modport slave (
        input  req_addr, req_valid, rsp_ready,
        output req_ready, rsp_data, rsp_idx, rsp_last, rsp_err, rsp_valid
    );
endinterface

// File: rtl/mxreg_read_sequencer_11_decoder.sv
// Combinational address decoder for the register read path.
// Ports:
//   addr    in  8  read address in the loader address map
//   idx0    out 4  register of the first (or only) beat
//   idx1    out 4  register of the second beat (pairs only, else 0)
//   is_pair out 1  address returns two beats
//   is_err  out 1  address is unmapped (idx0 = 0)
module mxreg_read_decoder_11
    import mxregs_pkg::*;
(
    input  logic [7:0] addr,
    output logic [3:0] idx0,
    output logic [3:0] idx1,
    output logic       is_pair,
    output logic       is_err
);

    always_comb begin
        idx0    = 4'd0;
        idx1    = 4'd0;
        is_pair = 1'b0;
        is_err  = 1'b0;
        if (addr[7:4] == 4'h0) begin
            idx0 = addr[3:0];
        end else if (addr inside {[ADDR_FLAGS_A:ADDR_FLAGS_D]}) begin
            idx0    = REG_FLAGS;
            idx1    = flags_partner(addr[1:0]);
            is_pair = 1'b1;
        end else if (addr == ADDR_R2_INSP) begin
            idx0    = REG_R2;
            idx1    = REG_INSP;
            is_pair = 1'b1;
        end else begin
            is_err = 1'b1;
        end
    end

endmodule

// File: rtl/mxreg_read_sequencer_11.sv
// Register bank read sequencer.
// Accepts a read address, decodes it with the loader address map and returns
// the register contents as one or two response beats. Both beats of a pair
// are taken from reg_line in the accept cycle, so a pair is a coherent
// snapshot even if the bank changes while the response is stalled.
// Ports:
//   clk       in   1                    clock, rising edge
//   rst       in   1                    synchronous reset, active-high
//   reg_line  in   DEPTH*WORD_LENGTH    packed bank, slice i = register i
//   bus       slave modport             request/response handshake signals
//   state     out  state_t              current FSM state (debug visibility)
module mxreg_read_sequencer_11
    import mxregs_pkg::*;
#(
    parameter int WORD_LENGTH = 8,
    parameter int DEPTH       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DEPTH*WORD_LENGTH-1:0] reg_line,
    mxreg_read_sequencer_11_if.slave     bus,
    output state_t                       state
);

    generate
        if (DEPTH != BANK_DEPTH) begin : g_depth_check
            $error("mxreg_read_sequencer_11: address map requires DEPTH == 16");
        end
    endgenerate

    // Bank unpacked for indexing by decoded register number
    logic [WORD_LENGTH-1:0] regs [BANK_DEPTH];

    always_comb begin
        for (int i = 0; i < BANK_DEPTH; i++) begin
            regs[i] = reg_line[i*WORD_LENGTH +: WORD_LENGTH];
        end
    end

    logic [3:0] dec_idx0;
    logic [3:0] dec_idx1;
    logic       dec_pair;
    logic       dec_err;

    mxreg_read_decoder_11 u_decoder (
        .addr    (bus.req_addr),
        .idx0    (dec_idx0),
        .idx1    (dec_idx1),
        .is_pair (dec_pair),
        .is_err  (dec_err)
    );

    // Registered state
    state_t                 state_q, state_d;
    logic                   valid_q, valid_d;
    logic [WORD_LENGTH-1:0] data_q, data_d;
    logic [3:0]             idx_q, idx_d;
    logic                   last_q, last_d;
    logic                   err_q, err_d;
    logic [WORD_LENGTH-1:0] hold_data_q, hold_data_d;
    logic [3:0]             hold_idx_q, hold_idx_d;

    logic req_ready;
    logic accept;
    logic consume;

    // A new request may enter only when the output slot is free or being
    // drained this very cycle; that is what lets singles stream without gaps.
    assign req_ready = !rst && (state_q == IDLE) && (!valid_q || bus.rsp_ready);
    assign accept    = bus.req_valid && req_ready;
    assign consume   = valid_q && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            data_q      <= '0;
            idx_q       <= 4'd0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            hold_data_q <= '0;
            hold_idx_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            err_q       <= err_d;
            hold_data_q <= hold_data_d;
            hold_idx_q  <= hold_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        data_d      = data_q;
        idx_d       = idx_q;
        last_d      = last_q;
        err_d       = err_q;
        hold_data_d = hold_data_q;
        hold_idx_d  = hold_idx_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Unmapped addresses return data 0; decoder already gives idx 0
                    valid_d = 1'b1;
                    data_d  = dec_err ? '0 : regs[dec_idx0];
                    idx_d   = dec_idx0;
                    last_d  = !dec_pair;
                    err_d   = dec_err;
                    if (dec_pair) begin
                        hold_data_d = regs[dec_idx1];
                        hold_idx_d  = dec_idx1;
                        state_d     = SECOND;
                    end
                end else if (consume) begin
                    valid_d = 1'b0;
                end
            end
            SECOND: begin
                if (consume) begin
                    valid_d = 1'b1;
                    data_d  = hold_data_q;
                    idx_d   = hold_idx_q;
                    last_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_idx   = idx_q;
    assign bus.rsp_last  = last_q;
    assign bus.rsp_err   = err_q;
    assign state         = state_q;

endmodule

// File: tb/tb_mxreg_read_sequencer_11.sv
// Directed testbench for mxreg_read_sequencer_11.
// Inputs are driven and outputs sampled on the falling clock edge, halfway
// between the rising edges where the DUT updates.
module tb_mxreg_read_sequencer_11;
    import mxregs_pkg::*;

    localparam int W = 8;
    localparam int N = 16;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] reg_line;
    logic [W-1:0]   model [N];
    state_t         state;

    int n_checks = 0;
    int n_pass   = 0;

    mxreg_read_sequencer_11_if #(.WORD_LENGTH(W)) bus ();

    mxreg_read_sequencer_11 #(
        .WORD_LENGTH (W),
        .DEPTH       (N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .reg_line (reg_line),
        .bus      (bus),
        .state    (state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            reg_line[i*W +: W] = model[i];
        end
    end

    // Checking task
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Driver tasks
    task automatic drive_req(input logic v, input logic [7:0] a);
        bus.req_valid = v;
        bus.req_addr  = a;
    endtask

    task automatic check_beat(input string tag, input logic [7:0] d, input logic [3:0] i,
                              input logic l, input logic e);
        check({tag, "_valid"}, bus.rsp_valid, 1'b1);
        check({tag, "_data"},  bus.rsp_data, d);
        check({tag, "_idx"},   bus.rsp_idx, i);
        check({tag, "_last"},  bus.rsp_last, l);
        check({tag, "_err"},   bus.rsp_err, e);
    endtask

    initial begin
        for (int i = 0; i < N; i++) model[i] = 8'h10 + 8'(i);
        rst           = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 8'h05;
        bus.rsp_ready = 1'b1;

        // Reset state
        step();
        step();
        check("rst_valid", bus.rsp_valid, 1'b0);
        check("rst_data",  bus.rsp_data, 8'h00);
        check("rst_idx",   bus.rsp_idx, 4'd0);
        check("rst_last",  bus.rsp_last, 1'b0);
        check("rst_err",   bus.rsp_err, 1'b0);
        check("rst_ready", bus.req_ready, 1'b0);
        check("rst_state", state, IDLE);

        // Single read, 1 cycle latency
        rst = 1'b0;
        drive_req(1'b1, 8'h05);
        #1 check("single_req_ready", bus.req_ready, 1'b1);
        step();
        check_beat("single", 8'h15, 4'd5, 1'b1, 1'b0);
        drive_req(1'b0, 8'h00);
        step();
        check("single_drain_valid", bus.rsp_valid, 1'b0);
        check("single_drain_hold",  bus.rsp_data, 8'h15);

        // FLAGS+Y pair
        model[REG_FLAGS] = 8'hA5;
        model[REG_Y]     = 8'h3C;
        drive_req(1'b1, 8'h12);
        step();
        check_beat("pair_b0", 8'hA5, 4'd7, 1'b0, 1'b0);
        check("pair_state", state, SECOND);
        check("pair_ready_between", bus.req_ready, 1'b0);
        drive_req(1'b0, 8'h00);
        step();
        check_beat("pair_b1", 8'h3C, 4'd2, 1'b1, 1'b0);
        check("pair_state_end", state, IDLE);
        step();
        check("pair_drain_valid", bus.rsp_valid, 1'b0);

        // R2+INSP pair under backpressure; bank changes during the stall
        bus.rsp_ready = 1'b0;
        drive_req(1'b1, 8'h80);
        step();
        drive_req(1'b0, 8'h00);
        model[REG_R2]   = 8'h77;
        model[REG_INSP] = 8'h66;
        step();
        step();
        step();
        check_beat("stall_b0", 8'h1E, 4'd14, 1'b0, 1'b0);
        check("stall_ready", bus.req_ready, 1'b0);
        bus.rsp_ready = 1'b1;
        step();
        check_beat("stall_b1", 8'h16, 4'd6, 1'b1, 1'b0);
        step();
        check("stall_drain_valid", bus.rsp_valid, 1'b0);

        // Unmapped addresses, then a consume+accept into a normal read
        drive_req(1'b1, 8'h14);
        step();
        check_beat("err14", 8'h00, 4'd0, 1'b1, 1'b1);
        drive_req(1'b1, 8'hFF);
        #1 check("err_ready_overlap", bus.req_ready, 1'b1);
        step();
        check_beat("errFF", 8'h00, 4'd0, 1'b1, 1'b1);
        drive_req(1'b1, 8'h03);
        step();
        check_beat("after_err", 8'h13, 4'd3, 1'b1, 1'b0);
        drive_req(1'b0, 8'h00);
        step();

        // Single beat stalled blocks new requests
        bus.rsp_ready = 1'b0;
        drive_req(1'b1, 8'h04);
        step();
        drive_req(1'b1, 8'h01);
        #1 check("single_stall_ready", bus.req_ready, 1'b0);
        step();
        check_beat("single_stall", 8'h14, 4'd4, 1'b1, 1'b0);
        drive_req(1'b0, 8'h00);
        bus.rsp_ready = 1'b1;
        step();
        check("single_stall_drain", bus.rsp_valid, 1'b0);

        // Back-to-back stream 00..03
        for (int a = 0; a < 4; a++) begin
            drive_req(1'b1, 8'(a));
            step();
            check_beat($sformatf("stream%0d", a), model[a], 4'(a), 1'b1, 1'b0);
        end
        drive_req(1'b0, 8'h00);
        step();
        check("stream_end_valid", bus.rsp_valid, 1'b0);

        // Reset during the second beat of an 8'h10 pair
        drive_req(1'b1, 8'h10);
        step();
        check_beat("rstpair_b0", 8'hA5, 4'd7, 1'b0, 1'b0);
        drive_req(1'b0, 8'h00);
        rst = 1'b1;
        step();
        check("rstpair_valid", bus.rsp_valid, 1'b0);
        check("rstpair_data",  bus.rsp_data, 8'h00);
        check("rstpair_last",  bus.rsp_last, 1'b0);
        check("rstpair_state", state, IDLE);
        rst = 1'b0;
        step();
        check("rstpair_no_b1", bus.rsp_valid, 1'b0);
        check("rstpair_idle",  state, IDLE);
        drive_req(1'b1, 8'h01);
        step();
        check_beat("rstpair_next", 8'h11, 4'd1, 1'b1, 1'b0);
        drive_req(1'b0, 8'h00);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
